// File: rtl/core_ctrl_wb_arb_if.sv
// Writeback bus between the execution units, the arbiter, the register file
// and the scoreboard retire port.
//   master : execution-unit / scoreboard side (drives *_wb_valid/rd_idx/data,
//            scb_ret_ready; observes *_wb_ready, rf_wr_*, scb_ret_reg_*)
//   slave  : the writeback arbiter
interface core_ctrl_wb_arb_if #(
  parameter int XLEN = 32
);
  logic            alu_wb_valid;
  logic            alu_wb_ready;
  logic [4:0]      alu_wb_rd_idx;
  logic [XLEN-1:0] alu_wb_data;
  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [4:0]      lsu_wb_rd_idx;
  logic [XLEN-1:0] lsu_wb_data;
  logic            mdu_wb_valid;
  logic            mdu_wb_ready;
  logic [4:0]      mdu_wb_rd_idx;
  logic [XLEN-1:0] mdu_wb_data;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_idx;
  logic [XLEN-1:0] rf_wr_data;
  logic            scb_ret_reg_valid;
  logic [4:0]      scb_ret_reg_idx;
  logic            scb_ret_ready;

  modport master (
    output alu_wb_valid, alu_wb_rd_idx, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd_idx, lsu_wb_data,
    output mdu_wb_valid, mdu_wb_rd_idx, mdu_wb_data,
    output scb_ret_ready,
    input  alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
    input  rf_wr_en, rf_wr_idx, rf_wr_data,
    input  scb_ret_reg_valid, scb_ret_reg_idx
  );

  modport slave (
    input  alu_wb_valid, alu_wb_rd_idx, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd_idx, lsu_wb_data,
    input  mdu_wb_valid, mdu_wb_rd_idx, mdu_wb_data,
    input  scb_ret_ready,
    output alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
    output rf_wr_en, rf_wr_idx, rf_wr_data,
    output scb_ret_reg_valid, scb_ret_reg_idx
  );
endinterface

// File: rtl/core_ctrl_wb_arb.sv
// Writeback/retire arbiter. Each execution unit (ALU, LSU, MDU) has a small
// result FIFO; one head per cycle is picked round-robin into a single output
// register that drives the scoreboard retire handshake and the register-file
// write port.
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : core_ctrl_wb_arb_if.slave (source handshakes, rf write, retire)

// Per-source result FIFO. Count is kept one bit wider than the pointers so
// full and empty are distinguishable; pointers wrap naturally (power-of-2 depth).
module core_ctrl_wb_arb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module core_ctrl_wb_arb #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  core_ctrl_wb_arb_if.slave     bus
);
  localparam int NUM_SRC = 3;   // 0=ALU 1=LSU 2=MDU, also the round-robin order

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  localparam int W = $bits(wb_ent_t);

  wb_ent_t [NUM_SRC-1:0] src_din, src_head;
  logic    [NUM_SRC-1:0] src_vld, src_rdy, src_push, src_pop, src_full, src_empty;

  // Ready is held low until the first edge after reset release.
  logic rdy_en;

  logic    [1:0] rr_ptr, rr_nxt, win;
  logic          grant, can_grant;
  logic          out_vld;
  wb_ent_t       out_ent;

  assign src_vld = {bus.mdu_wb_valid, bus.lsu_wb_valid, bus.alu_wb_valid};
  assign src_din[0] = '{rd: bus.alu_wb_rd_idx, data: bus.alu_wb_data};
  assign src_din[1] = '{rd: bus.lsu_wb_rd_idx, data: bus.lsu_wb_data};
  assign src_din[2] = '{rd: bus.mdu_wb_rd_idx, data: bus.mdu_wb_data};

  // Ready comes from registered state only; a same-cycle pop does not open a
  // full FIFO, which keeps valid/scb_ret_ready off the ready path.
  assign src_rdy  = {NUM_SRC{rdy_en}} & ~src_full;
  assign src_push = src_vld & src_rdy;

  assign bus.alu_wb_ready = src_rdy[0];
  assign bus.lsu_wb_ready = src_rdy[1];
  assign bus.mdu_wb_ready = src_rdy[2];

  core_ctrl_wb_arb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo [NUM_SRC-1:0] (
    .clk   (clk),
    .rstn  (rstn),
    .push  (src_push),
    .din   (src_din),
    .pop   (src_pop),
    .dout  (src_head),
    .full  (src_full),
    .empty (src_empty)
  );

  // Round-robin pick: first non-empty source scanning from rr_ptr.
  always_comb begin
    logic [2:0] cand;
    logic       found;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
      if (!found && !src_empty[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
    can_grant = !out_vld || bus.scb_ret_ready;
    grant     = can_grant && found;
    rr_nxt    = grant ? ((win == 2'(NUM_SRC - 1)) ? 2'd0 : win + 2'd1) : rr_ptr;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pop
    assign src_pop[i] = grant && (win == 2'(i));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en  <= 1'b0;
      rr_ptr  <= '0;
      out_vld <= 1'b0;
      out_ent <= '0;
    end else begin
      rdy_en <= 1'b1;
      rr_ptr <= rr_nxt;
      if (grant) begin
        out_vld <= 1'b1;
        out_ent <= src_head[win];
      end else if (out_vld && bus.scb_ret_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.scb_ret_reg_valid = out_vld;
  assign bus.scb_ret_reg_idx   = out_ent.rd;
  assign bus.rf_wr_idx         = out_ent.rd;
  assign bus.rf_wr_data        = out_ent.data;
  // x0 still retires (scoreboard tracks it) but is never written.
  assign bus.rf_wr_en          = out_vld && bus.scb_ret_ready && (out_ent.rd != 5'd0);
endmodule

// File: tb/tb_core_ctrl_wb_arb.sv
module tb_core_ctrl_wb_arb;
  localparam int XLEN = 32;

  logic clk, rstn;
  core_ctrl_wb_arb_if #(.XLEN(XLEN)) bus ();

  core_ctrl_wb_arb #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t expq[$];
  int   npass = 0, ntot = 0, nwr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Retire monitor: every accepted retire is compared with the scoreboard head.
  task automatic mon();
    exp_t e;
    if (bus.scb_ret_reg_valid && bus.scb_ret_ready) begin
      if (expq.size() == 0) chk("unexpected_retire", {59'd0, bus.scb_ret_reg_idx}, 64'hdead);
      else begin
        e = expq.pop_front();
        chk("ret_idx", {59'd0, bus.scb_ret_reg_idx}, {59'd0, e.rd});
        chk("rf_idx",  {59'd0, bus.rf_wr_idx}, {59'd0, e.rd});
        chk("rf_data", {32'd0, bus.rf_wr_data}, {32'd0, e.data});
      end
      chk("rf_wr_en", {63'd0, bus.rf_wr_en}, {63'd0, bus.scb_ret_reg_idx != 5'd0});
      if (bus.rf_wr_en) nwr++;
    end else begin
      chk("rf_wr_en_idle", {63'd0, bus.rf_wr_en}, 64'd0);
    end
  endtask

  task automatic neg(); @(negedge clk); mon(); endtask
  task automatic pos(); @(posedge clk); #1; endtask
  task automatic cyc(); neg(); pos(); endtask

  task automatic clr_in();
    bus.alu_wb_valid = 0; bus.alu_wb_rd_idx = 0; bus.alu_wb_data = 0;
    bus.lsu_wb_valid = 0; bus.lsu_wb_rd_idx = 0; bus.lsu_wb_data = 0;
    bus.mdu_wb_valid = 0; bus.mdu_wb_rd_idx = 0; bus.mdu_wb_data = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    chk({tag, "_idx"},   {59'd0, bus.scb_ret_reg_idx}, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, bus.rf_wr_en}, 64'd0);
    chk({tag, "_wr_idx"}, {59'd0, bus.rf_wr_idx}, 64'd0);
    chk({tag, "_wr_data"}, {32'd0, bus.rf_wr_data}, 64'd0);
    chk({tag, "_ready"}, {61'd0, bus.alu_wb_ready, bus.lsu_wb_ready, bus.mdu_wb_ready}, 64'd0);
  endtask

  // Called at a posedge+1 point; returns at posedge+1 of cycle 0 after release.
  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk_all_zero(tag);
    clr_in();
    bus.scb_ret_ready = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk({tag, "_ready_at_release"}, {61'd0, bus.alu_wb_ready, bus.lsu_wb_ready, bus.mdu_wb_ready}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {61'd0, bus.alu_wb_ready, bus.lsu_wb_ready, bus.mdu_wb_ready}, 64'h7);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wr0;
    rstn = 1'b1;
    clr_in();
    bus.scb_ret_ready = 1'b1;
    @(posedge clk); #1;
    do_reset("rst");

    // T1 single ALU result, 2-cycle latency
    bus.alu_wb_valid = 1; bus.alu_wb_rd_idx = 5; bus.alu_wb_data = 32'h1234;
    expq.push_back('{5, 32'h1234});
    cyc();
    clr_in();
    neg();                                   // cycle 1
    chk("t1_c1_valid", {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    pos();
    @(negedge clk);                          // cycle 2
    chk("t1_c2_valid", {63'd0, bus.scb_ret_reg_valid}, 64'd1);
    chk("t1_c2_idx",   {59'd0, bus.scb_ret_reg_idx}, 64'd5);
    chk("t1_c2_wr_en", {63'd0, bus.rf_wr_en}, 64'd1);
    chk("t1_c2_data",  {32'd0, bus.rf_wr_data}, 64'h1234);
    mon();
    pos();
    neg();                                   // cycle 3
    chk("t1_c3_idle", {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    pos();

    // T2 contention from rr_ptr=ALU
    do_reset("rst_t2");
    bus.alu_wb_valid = 1; bus.alu_wb_rd_idx = 1; bus.alu_wb_data = 32'h101;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd_idx = 2; bus.lsu_wb_data = 32'h102;
    bus.mdu_wb_valid = 1; bus.mdu_wb_rd_idx = 3; bus.mdu_wb_data = 32'h103;
    expq.push_back('{1, 32'h101});
    expq.push_back('{2, 32'h102});
    expq.push_back('{3, 32'h103});
    cyc();
    clr_in();
    cyc();
    for (int c = 2; c <= 4; c++) begin
      neg();
      chk($sformatf("t2_c%0d_idx", c), {58'd0, bus.scb_ret_reg_valid, bus.scb_ret_reg_idx},
          {58'd0, 1'b1, 5'(c - 1)});
      pos();
    end
    // next round: MDU and ALU together, rr_ptr back at ALU
    bus.mdu_wb_valid = 1; bus.mdu_wb_rd_idx = 7; bus.mdu_wb_data = 32'h707;
    bus.alu_wb_valid = 1; bus.alu_wb_rd_idx = 8; bus.alu_wb_data = 32'h808;
    expq.push_back('{8, 32'h808});
    expq.push_back('{7, 32'h707});
    cyc();
    clr_in();
    cyc();
    neg();
    chk("t2_r2_first", {59'd0, bus.scb_ret_reg_idx}, 64'd8);
    pos();
    repeat (3) cyc();
    chk("t2_drained", 64'(expq.size()), 64'd0);

    // T3 backpressure cycles 2-4
    wr0 = nwr;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd_idx = 9; bus.lsu_wb_data = 32'h9999;
    expq.push_back('{9, 32'h9999});
    cyc();
    clr_in();
    cyc();
    bus.scb_ret_ready = 0;
    for (int c = 2; c <= 4; c++) begin
      neg();
      chk($sformatf("t3_c%0d_hold", c),
          {26'd0, bus.scb_ret_reg_valid, bus.scb_ret_reg_idx, bus.rf_wr_data},
          {26'd0, 1'b1, 5'd9, 32'h9999});
      pos();
    end
    bus.scb_ret_ready = 1;
    neg();
    chk("t3_c5_wr_en", {63'd0, bus.rf_wr_en}, 64'd1);
    pos();
    neg();
    chk("t3_c6_idle", {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    pos();
    chk("t3_one_write", 64'(nwr - wr0), 64'd1);

    // T4 full LSU path with retire stalled
    bus.scb_ret_ready = 0;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd_idx = 10; bus.lsu_wb_data = 32'ha0;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) bus.scb_ret_ready = 1;
      neg();
      if (c == 3) begin
        chk("t4_accepted_before_full", 64'(acc), 64'd3);
        chk("t4_ready_low", {63'd0, bus.lsu_wb_ready}, 64'd0);
      end
      if (bus.lsu_wb_valid && bus.lsu_wb_ready) begin
        expq.push_back('{bus.lsu_wb_rd_idx, bus.lsu_wb_data});
        acc++;
      end
      pos();
      if (acc == 4) bus.lsu_wb_valid = 0;
      else if (bus.lsu_wb_valid && acc == bus.lsu_wb_rd_idx - 5'd9) begin
        bus.lsu_wb_rd_idx = bus.lsu_wb_rd_idx + 5'd1;
        bus.lsu_wb_data   = bus.lsu_wb_data + 32'h1;
      end
    end
    clr_in();
    chk("t4_all_accepted", 64'(acc), 64'd4);
    chk("t4_drained", 64'(expq.size()), 64'd0);

    // T5 x0 retire without a write
    bus.mdu_wb_valid = 1; bus.mdu_wb_rd_idx = 0; bus.mdu_wb_data = 32'hffff;
    expq.push_back('{0, 32'hffff});
    cyc();
    clr_in();
    cyc();
    neg();
    chk("t5_valid", {58'd0, bus.scb_ret_reg_valid, bus.scb_ret_reg_idx}, {58'd0, 1'b1, 5'd0});
    chk("t5_wr_en", {63'd0, bus.rf_wr_en}, 64'd0);
    pos();
    cyc();

    // T6 reset with output valid and two entries buffered
    bus.scb_ret_ready = 0;
    bus.alu_wb_valid = 1; bus.alu_wb_rd_idx = 20; bus.alu_wb_data = 32'h20;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd_idx = 21; bus.lsu_wb_data = 32'h21;
    bus.mdu_wb_valid = 1; bus.mdu_wb_rd_idx = 22; bus.mdu_wb_data = 32'h22;
    cyc();
    clr_in();
    cyc();
    neg();
    chk("t6_pre_valid", {63'd0, bus.scb_ret_reg_valid}, 64'd1);
    pos();
    do_reset("t6_rst");
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd_idx = 31; bus.lsu_wb_data = 32'h31;
    bus.alu_wb_valid = 1; bus.alu_wb_rd_idx = 30; bus.alu_wb_data = 32'h30;
    expq.push_back('{30, 32'h30});
    expq.push_back('{31, 32'h31});
    neg();
    chk("t6_no_stale_c0", {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    pos();
    clr_in();
    neg();
    chk("t6_no_stale_c1", {63'd0, bus.scb_ret_reg_valid}, 64'd0);
    pos();
    neg();
    chk("t6_alu_first", {58'd0, bus.scb_ret_reg_valid, bus.scb_ret_reg_idx}, {58'd0, 1'b1, 5'd30});
    pos();
    repeat (4) cyc();
    chk("t6_drained", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
